// File: rtl/char_scroll_pkg.sv
// +----------------------------------------------------------------------------+
// | char_scroll_pkg : shared widths, character codes, segment patterns, slot   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package char_scroll_pkg;

  localparam int CODE_W     = 3;
  localparam int NUM_DIGITS = 4;

  localparam logic [CODE_W-1:0] CODE_H = 3'd0;
  localparam logic [CODE_W-1:0] CODE_E = 3'd1;
  localparam logic [CODE_W-1:0] CODE_L = 3'd2;
  localparam logic [CODE_W-1:0] CODE_O = 3'd3;

  // Active-low, bit order g f e d c b a
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic              blank;
    logic [CODE_W-1:0] code;
  } slot_t;

  localparam slot_t SLOT_BLANK = '{blank: 1'b1, code: '0};

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// +----------------------------------------------------------------------------+
// | seg_decode : one display slot to active-low 7-segment pattern              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_decode
  import char_scroll_pkg::*;
(
  input  slot_t      i_slot,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_slot.blank) begin
      case (i_slot.code)
        CODE_H:  o_seg = SEG_H;
        CODE_E:  o_seg = SEG_E;
        CODE_L:  o_seg = SEG_L;
        CODE_O:  o_seg = SEG_O;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/char_scroll.sv
// +----------------------------------------------------------------------------+
// | char_scroll : 4-digit character buffer with load and timed left scroll     |
// | Option: CHAR_SCROLL_LOOP_EN makes the scroll circular instead of blanking  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module char_scroll
  import char_scroll_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [CODE_W-1:0] D,
  input  logic              Load,
  input  logic              Run,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX0,
  output logic              Tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  slot_t [NUM_DIGITS-1:0] r_buf;
  logic  [CNT_W-1:0]      r_cnt;

  logic       w_term;
  logic       w_step;
  slot_t      w_load_slot;
  slot_t      w_fill;
  logic [6:0] w_seg [NUM_DIGITS];

  assign w_term      = (r_cnt == CNT_W'(TICK_DIV - 1));
  // Load wins over a coinciding scroll step; the counter wraps regardless
  assign w_step      = Run && w_term && !Load;
  assign Tick        = w_step && !Reset;
  assign w_load_slot = '{blank: 1'b0, code: D};

`ifdef CHAR_SCROLL_LOOP_EN
  assign w_fill = r_buf[NUM_DIGITS-1];
`else
  assign w_fill = SLOT_BLANK;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_buf <= {NUM_DIGITS{SLOT_BLANK}};
      r_cnt <= '0;
    end else begin
      if (Run) begin
        r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      end
      if (Load) begin
        r_buf <= {r_buf[NUM_DIGITS-2:0], w_load_slot};
      end else if (w_step) begin
        r_buf <= {r_buf[NUM_DIGITS-2:0], w_fill};
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seg_decode u_dec (
      .i_slot (r_buf[k]),
      .o_seg  (w_seg[k])
    );
  end

  assign HEX0 = w_seg[0];
  assign HEX1 = w_seg[1];
  assign HEX2 = w_seg[2];
  assign HEX3 = w_seg[3];

endmodule

`default_nettype wire

// File: tb/tb_char_scroll.sv
// +----------------------------------------------------------------------------+
// | tb_char_scroll : directed + random checks of char_scroll against a model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_char_scroll;

  localparam int TICK_DIV = 4;

  logic       Clock;
  logic       Reset;
  logic [2:0] D;
  logic       Load;
  logic       Run;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;
  logic       Tick;

  int n_cmp;
  int n_err;

  // Model: queue of characters, index 0 is the leftmost digit, -1 means blank
  int m_disp[$];
  int m_cnt;

  char_scroll #(.TICK_DIV(TICK_DIV)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .D     (D),
    .Load  (Load),
    .Run   (Run),
    .HEX3  (HEX3),
    .HEX2  (HEX2),
    .HEX1  (HEX1),
    .HEX0  (HEX0),
    .Tick  (Tick)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [6:0] exp_seg(input int c);
    case (c)
      0:       return 7'b0001001;
      1:       return 7'b0000110;
      2:       return 7'b1000111;
      3:       return 7'b1000000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [2:0] d,
                      input logic run, input bit chk_hex);
    logic       exp_tick;
    logic [6:0] obs [4];
    int         t;
    Reset = rst;
    Load  = ld;
    D     = d;
    Run   = run;
    @(negedge Clock);
    exp_tick = !rst && run && !ld && (m_cnt == TICK_DIV - 1);
    chk1("tick", Tick, exp_tick);
    if (chk_hex) begin
      obs[0] = HEX3; obs[1] = HEX2; obs[2] = HEX1; obs[3] = HEX0;
      for (int k = 0; k < 4; k++)
        chk7($sformatf("hex%0d", 3 - k), obs[k], exp_seg(m_disp[k]));
    end
    @(posedge Clock);
    if (rst) begin
      m_disp = '{-1, -1, -1, -1};
      m_cnt  = 0;
    end else begin
      if (ld) begin
        void'(m_disp.pop_front());
        m_disp.push_back(int'(d));
      end else if (exp_tick) begin
        t = m_disp.pop_front();
`ifdef CHAR_SCROLL_LOOP_EN
        m_disp.push_back(t);
`else
        m_disp.push_back(-1);
`endif
      end
      if (run) m_cnt = (m_cnt + 1) % TICK_DIV;
    end
    #1;
  endtask

  task automatic run_to_count(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 2 * TICK_DIV) begin
      step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      guard++;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    m_disp = '{-1, -1, -1, -1};
    m_cnt  = 0;
    Reset  = 1'b1;
    Load   = 1'b1;
    D      = 3'd0;
    Run    = 1'b1;

    // Reset held two cycles with Load and Run active
    step(1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd1, 1'b1, 1'b1);

    // Load H,E,L,O with Run low, then idle
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    chk7("helo_hex3", HEX3, 7'b0001001);
    chk7("helo_hex2", HEX2, 7'b0000110);
    chk7("helo_hex1", HEX1, 7'b1000111);
    chk7("helo_hex0", HEX0, 7'b1000000);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, $urandom_range(7), 1'b0, 1'b1);

    // Scrolling
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Load colliding with terminal count
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i), 1'b0, 1'b1);
    run_to_count(TICK_DIV - 1);
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Reset in the middle of a count
    run_to_count(2);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Invalid codes stay non-blank for shifting
    step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    chk7("inv_hex3", HEX3, 7'b0001001);
    chk7("inv_hex0", HEX0, 7'b1111111);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(3) == 0), 3'($urandom_range(7)),
           ($urandom_range(3) != 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/char_scroll.md
CHAR_SCROLL -- requirements
Module: char_scroll

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, giving the Clock cycles per scroll step (0.5 s at 50 MHz); legal values are 2 or more.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port D, input, 3 bits: character code from the upstream 3-bit register stage.
REQ-005 SHALL have port Load, input, 1 bit: push D into the display buffer.
REQ-006 SHALL have port Run, input, 1 bit: enables the tick counter and scrolling.
REQ-007 SHALL have ports HEX3, HEX2, HEX1 and HEX0, each output, 7 bits: active-low segments, bit order g f e d c b a; HEX3 is the leftmost digit.
REQ-008 SHALL have port Tick, output, 1 bit: one-cycle pulse on each scroll step.

Function
REQ-009 SHALL hold a 4-slot buffer. Each slot is a 3-bit code plus a blank flag. Slot k drives HEXk.
REQ-010 SHALL, on a rising edge with Load=1, shift the buffer left (slot3 is discarded, slot k takes slot k-1) and write D into slot0 as non-blank.
REQ-011 SHALL keep a tick counter that counts 0 to TICK_DIV-1 while Run=1, holds its value while Run=0, and wraps to 0 after TICK_DIV-1.
REQ-012 SHALL, when the counter is at TICK_DIV-1 with Run=1 and Load=0, rotate the buffer left one slot and assert Tick for exactly that cycle.
REQ-013 SHALL give Load priority when Load and terminal count coincide: the load is applied, the scroll step is dropped, Tick stays 0, and the counter still wraps to 0.
REQ-014 SHALL decode each slot combinationally from the registered buffer: HEX reflects a Load or scroll on the first cycle after the edge.
REQ-015 SHALL use this decode: code 0 -> 'H' 7'b0001001; 1 -> 'E' 7'b0000110; 2 -> 'L' 7'b1000111; 3 -> 'O' 7'b1000000; codes 4-7 and blank slots -> 7'b1111111.
REQ-016 SHALL treat a blank slot like any other slot when shifting or rotating.
REQ-017 SHALL not change the buffer or assert Tick while Run=0 and Load=0.

Reset
REQ-018 SHALL, on a rising edge with Reset=1, set every slot to blank, the counter to 0 and Tick to 0, so that HEX3 through HEX0 read 7'b1111111 on the next cycle.
REQ-019 SHALL give Reset priority over Load and Run, including when Reset arrives in the middle of a count.
REQ-020 SHALL make the first Tick after Reset is released occur TICK_DIV cycles of Run=1 later.

Configuration
REQ-021 SHALL, when macro CHAR_SCROLL_LOOP_EN is defined, rotate circularly on each scroll step: slot3 content moves into slot0.
REQ-022 SHALL, when CHAR_SCROLL_LOOP_EN is undefined, shift in a blank slot at slot0 on each scroll step; after 4 steps the display is fully blank.

Structure
REQ-023 SHALL take from shared package char_scroll_pkg: CODE_W=3, NUM_DIGITS=4, the code constants CODE_H/E/L/O, the segment constants SEG_H/E/L/O/BLANK, and the slot typedef (code plus blank).
REQ-024 SHALL place the decoder in sub-module seg_decode (slot in, 7-bit segments out), instantiated 4 times.

Verification
REQ-025 SHALL cover reset: hold Reset for 2 cycles with Load=1 and Run=1 -> HEX3..0 all 7'b1111111 and Tick=0 throughout.
REQ-026 SHALL cover loading: with Run=0, load codes 0,1,2,3 on consecutive cycles -> HEX3..0 read H,E,L,O and stay unchanged for 20 more cycles.
REQ-027 SHALL cover scrolling: with TICK_DIV=4, the HELO buffer and Run=1 -> Tick on every 4th cycle; after the first Tick HEX3..0 read E,L,O,H with LOOP_EN defined, or E,L,O,blank without it.
REQ-028 SHALL cover the Load/terminal-count collision: with TICK_DIV=4, assert Load with D=3 exactly at count 3 -> the buffer shifts in 'O', there is no rotate, Tick=0, and the next Tick comes 4 cycles later.
REQ-029 SHALL cover reset mid-operation: assert Reset at count 2 -> next cycle all blank and count 0; the first Tick comes 4 Run cycles after release.
REQ-030 SHALL cover invalid codes: load D=5, 6 and 7 -> the affected slots display 7'b1111111 and the slots stay non-blank for the purpose of shifting.
